// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the key conditioner
//
// Contents:
//   key_state_t         per-channel FSM state, 3-bit encoding
//   KEY_DEB_20MS        default debounce length at 50 MHz
//   KEY_REP_DELAY_500MS default hold time before the first auto-repeat
//   KEY_REP_RATE_100MS  default interval between auto-repeats
//   key_max3()          largest of three cycle counts, used to size counters

package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_CHK = 3'd1,
    ST_HELD      = 3'd2,
    ST_REPEAT    = 3'd3,
    ST_REL_CHK   = 3'd4
  } key_state_t;

  localparam int unsigned KEY_DEB_20MS        = 1_000_000;
  localparam int unsigned KEY_REP_DELAY_500MS = 25_000_000;
  localparam int unsigned KEY_REP_RATE_100MS  = 5_000_000;

  function automatic int unsigned key_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchroniser, debounce FSM, repeat timer
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   key_n  in   raw key pin, 0 = pressed
//   press  out  one-cycle pulse per accepted press
//   step   out  one-cycle pulse on press and on every auto-repeat
//   held   out  debounced pressed level

module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = KEY_DEB_20MS,
  parameter int unsigned REPEAT_DELAY_CYCLES = KEY_REP_DELAY_500MS,
  parameter int unsigned REPEAT_RATE_CYCLES  = KEY_REP_RATE_100MS,
  parameter bit          REPEAT_EN           = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press,
  output logic step,
  output logic held
);

  localparam int unsigned CNT_W =
    $clog2(key_max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  // A zero repeat delay degenerates to "first repeat one cycle after press".
  localparam logic [CNT_W-1:0] DELAY_LAST =
    CNT_W'((REPEAT_DELAY_CYCLES == 32'd0) ? 32'd0 : REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);

  logic             sync_q1;
  logic             s;
  key_state_t       state;
  key_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             deb_done;
  logic             delay_done;
  logic             rate_done;
  logic             press_nxt;
  logic             step_nxt;
  logic             held_nxt;

  // Two-flop synchroniser; resets to the released level so a key held
  // through reset is seen as a fresh falling edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      s       <= 1'b1;
    end else begin
      sync_q1 <= key_n;
      s       <= sync_q1;
    end
  end

  assign deb_done   = (cnt == DEB_LAST);
  assign delay_done = (cnt == DELAY_LAST);
  assign rate_done  = (cnt == RATE_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shared interval counter: cleared on every state entry and while idle,
  // otherwise counts up and sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!s) begin
          state_nxt = ST_PRESS_CHK;
        end
      end
      ST_PRESS_CHK: begin
        if (s) begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end else if (deb_done) begin
          state_nxt = ST_HELD;
          cnt_clr   = 1'b1;
        end
      end
      ST_HELD: begin
        if (s) begin
          state_nxt = ST_REL_CHK;
          cnt_clr   = 1'b1;
        end else if (REPEAT_EN && delay_done) begin
          state_nxt = ST_REPEAT;
          cnt_clr   = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (s) begin
          state_nxt = ST_REL_CHK;
          cnt_clr   = 1'b1;
        end else if (rate_done) begin
          cnt_clr = 1'b1;
        end
      end
      ST_REL_CHK: begin
        // A low glitch while releasing counts as still held; the repeat
        // delay restarts from the re-entry into HELD.
        if (!s) begin
          state_nxt = ST_HELD;
          cnt_clr   = 1'b1;
        end else if (deb_done) begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // Output decode; values are registered below so nothing reaches the
  // ports combinationally from key_n.
  always_comb begin
    press_nxt = (state == ST_PRESS_CHK) && !s && deb_done;
    step_nxt  = press_nxt
              | ((state == ST_HELD) && !s && REPEAT_EN && delay_done)
              | ((state == ST_REPEAT) && !s && rate_done);
    held_nxt  = (state_nxt == ST_HELD) || (state_nxt == ST_REPEAT) ||
                (state_nxt == ST_REL_CHK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press <= 1'b0;
      step  <= 1'b0;
      held  <= 1'b0;
    end else begin
      press <= press_nxt;
      step  <= step_nxt;
      held  <= held_nxt;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-channel push-button conditioner (top)
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   key_n  in   [N_KEYS] raw key pins, 0 = pressed
//   press  out  [N_KEYS] one-cycle pulse per accepted press
//   step   out  [N_KEYS] press pulse plus auto-repeat pulses while held
//   held   out  [N_KEYS] debounced pressed level
//
// Channels are independent; simultaneous presses pulse in the same cycle.

module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS              = 3,
  parameter int unsigned DEBOUNCE_CYCLES     = KEY_DEB_20MS,
  parameter int unsigned REPEAT_DELAY_CYCLES = KEY_REP_DELAY_500MS,
  parameter int unsigned REPEAT_RATE_CYCLES  = KEY_REP_RATE_100MS,
  parameter bit          REPEAT_EN           = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] step,
  output logic [N_KEYS-1:0] held
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .REPEAT_EN          (REPEAT_EN)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .key_n(key_n[i]),
      .press(press[i]),
      .step (step[i]),
      .held (held[i])
    );
  end

endmodule
